// File: rtl/dram_rowbuf.sv
// Single-bank DRAM model: open-row policy with precharge/activate latencies,
// periodic refresh, byte-lane writes and a valid/ready request port.
module dram_rowbuf #(
  parameter int unsigned ADDR_WIDTH       = 8,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ROWS             = 4,
  parameter int unsigned COLS             = 16,
  parameter int unsigned T_ACT            = 2,
  parameter int unsigned T_PRE            = 2,
  parameter int unsigned T_REF            = 4,
  parameter int unsigned REFRESH_INTERVAL = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic                    write_enable,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rdata_valid,
  output logic                    row_open,
  output logic                    refreshing
);

  localparam int unsigned CW     = $clog2(COLS);
  localparam int unsigned RW     = $clog2(ROWS);
  localparam int unsigned IdxW   = CW + RW;
  localparam int unsigned Words  = ROWS * COLS;
  localparam int unsigned BeW    = DATA_WIDTH / 8;
  localparam int unsigned LatMax = (T_ACT > T_PRE) ? ((T_ACT > T_REF) ? T_ACT : T_REF)
                                                   : ((T_PRE > T_REF) ? T_PRE : T_REF);
  localparam int unsigned LatW   = $clog2(LatMax + 1);
  localparam int unsigned RefW   = $clog2(REFRESH_INTERVAL);

  typedef enum logic [2:0] {StIdle, StOpen, StPre, StAct, StRef} state_e;

  state_e                state_q, state_d;
  logic [LatW-1:0]       lat_q, lat_d;
  logic [RefW-1:0]       ref_cnt_q;
  logic [RW-1:0]         open_row_q, open_row_d;
  logic                  row_open_q, row_open_d;
  logic                  pend_q, pend_d;
  logic [IdxW-1:0]       pend_idx_q;
  logic [DATA_WIDTH-1:0] pend_wdata_q;
  logic [BeW-1:0]        pend_be_q;
  logic                  pend_we_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rdata_valid_q;
  logic [DATA_WIDTH-1:0] mem_q [Words];

  logic                  ref_pending, accept, latch, ref_enter;
  logic                  acc_en, acc_we;
  logic [IdxW-1:0]       acc_idx;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [BeW-1:0]        acc_be;
  logic [IdxW-1:0]       req_idx;
  logic [RW-1:0]         req_row;

  if (ADDR_WIDTH > IdxW) begin : g_unused_addr
    logic unused_addr;
    assign unused_addr = ^addr[ADDR_WIDTH-1:IdxW];
  end

  assign req_idx     = addr[IdxW-1:0];
  assign req_row     = addr[IdxW-1:CW];
  assign ref_pending = (ref_cnt_q == RefW'(REFRESH_INTERVAL - 1));
  // Gated by rst so the port reads not-ready for the whole reset assertion.
  assign req_ready   = rst && ((state_q == StIdle) || (state_q == StOpen)) && !ref_pending;
  assign accept      = req_valid && req_ready;

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign row_open    = row_open_q;
  assign refreshing  = (state_q == StRef);

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    open_row_d = open_row_q;
    row_open_d = row_open_q;
    pend_d     = pend_q;
    latch      = 1'b0;
    ref_enter  = 1'b0;
    acc_en     = 1'b0;
    acc_we     = write_enable;
    acc_idx    = req_idx;
    acc_wdata  = wdata;
    acc_be     = byte_en;
    unique case (state_q)
      StIdle: begin
        if (ref_pending) begin
          state_d   = StRef;
          lat_d     = LatW'(T_REF - 1);
          ref_enter = 1'b1;
        end else if (accept) begin
          latch   = 1'b1;
          pend_d  = 1'b1;
          state_d = StAct;
          lat_d   = LatW'(T_ACT - 1);
        end
      end
      StOpen: begin
        if (ref_pending) begin
          state_d = StPre;
          lat_d   = LatW'(T_PRE - 1);
        end else if (accept) begin
          if (req_row == open_row_q) begin
            acc_en = 1'b1;
          end else begin
            latch   = 1'b1;
            pend_d  = 1'b1;
            state_d = StPre;
            lat_d   = LatW'(T_PRE - 1);
          end
        end
      end
      StPre: begin
        if (lat_q == '0) begin
          // A latched request means a row miss; otherwise this is a refresh precharge.
          if (pend_q) begin
            state_d = StAct;
            lat_d   = LatW'(T_ACT - 1);
          end else begin
            state_d    = StRef;
            lat_d      = LatW'(T_REF - 1);
            ref_enter  = 1'b1;
            row_open_d = 1'b0;
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      StAct: begin
        if (lat_q == '0) begin
          acc_en     = 1'b1;
          acc_we     = pend_we_q;
          acc_idx    = pend_idx_q;
          acc_wdata  = pend_wdata_q;
          acc_be     = pend_be_q;
          open_row_d = pend_idx_q[IdxW-1:CW];
          row_open_d = 1'b1;
          pend_d     = 1'b0;
          state_d    = StOpen;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      StRef: begin
        if (lat_q == '0) begin
          state_d = StIdle;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      lat_q         <= '0;
      open_row_q    <= '0;
      row_open_q    <= 1'b0;
      pend_q        <= 1'b0;
      pend_idx_q    <= '0;
      pend_wdata_q  <= '0;
      pend_be_q     <= '0;
      pend_we_q     <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lat_q         <= lat_d;
      open_row_q    <= open_row_d;
      row_open_q    <= row_open_d;
      pend_q        <= pend_d;
      rdata_valid_q <= acc_en && !acc_we;
      if (latch) begin
        pend_idx_q   <= req_idx;
        pend_wdata_q <= wdata;
        pend_be_q    <= byte_en;
        pend_we_q    <= write_enable;
      end
      if (acc_en && !acc_we) begin
        rdata_q <= mem_q[acc_idx];
      end
    end
  end

  // The interval counter saturates so the pending request stays up until serviced.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt_q <= '0;
    end else if (ref_enter) begin
      ref_cnt_q <= '0;
    end else if (state_q != StRef && !ref_pending) begin
      ref_cnt_q <= ref_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < Words; w++) begin
        mem_q[w] <= '0;
      end
    end else if (acc_en && acc_we) begin
      for (int b = 0; b < BeW; b++) begin
        if (acc_be[b]) begin
          mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: doc/dram_rowbuf.md
# dram_rowbuf

Parametrised single-bank DRAM model with an open-row policy, activate/precharge latencies, periodic refresh, byte-lane writes and a valid/ready request port. It is the next-generation data memory behind the CPU load/store path, replacing the fixed-latency array with one whose access time depends on row state. Storage is organised as ROWS x COLS words of DATA_WIDTH bits.

## Interface
- ADDR_WIDTH, 8: word address width; must be >= log2(ROWS) + log2(COLS); upper excess bits ignored
- DATA_WIDTH, 32: word width; multiple of 8
- ROWS, 4: number of rows; power of two, >= 2
- COLS, 16: words per row; power of two, >= 2
- T_ACT, 2: activate latency in cycles, >= 1
- T_PRE, 2: precharge latency in cycles, >= 1
- T_REF, 4: refresh duration in cycles, >= 1
- REFRESH_INTERVAL, 64: cycles between refresh requests, > T_PRE + T_ACT + T_REF
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge
- addr  in  ADDR_WIDTH  word address; col = addr[CW-1:0], row = addr[CW+RW-1:CW]
- wdata  in  DATA_WIDTH  write data
- byte_en  in  DATA_WIDTH/8  write lane enables; ignored for reads
- write_enable  in  1  1 = write, 0 = read
- rdata  out  DATA_WIDTH  read data, held until next read completes
- rdata_valid  out  1  one-cycle pulse when a read completes
- row_open  out  1  a row is currently open
- refreshing  out  1  high while in REFRESH

## Operation
- States: IDLE (no open row), OPEN (row open_row active), PRECHARGE, ACTIVATE, REFRESH.
- req_ready = (IDLE or OPEN) && !refresh_pending; combinational from state; 0 while rst low.
- Accept in OPEN, row == open_row (hit): write commits at the accept edge on enabled lanes; read captures array into rdata, rdata_valid high next cycle. Stay OPEN.
- Accept in OPEN, row != open_row (miss): latch request; PRECHARGE for T_PRE cycles, ACTIVATE for T_ACT cycles; access performed at the edge leaving ACTIVATE; open_row = new row; go OPEN.
- Accept in IDLE: latch request; ACTIVATE for T_ACT cycles; access at exit edge; go OPEN.
- Writes: lane i updated only if byte_en[i]; byte_en = 0 is a legal no-op write (still opens the row).
- Refresh counter: increments every cycle outside REFRESH; at REFRESH_INTERVAL-1 sets refresh_pending and saturates.
- Pending refresh is serviced only from IDLE or OPEN (an in-flight miss completes first): OPEN -> PRECHARGE -> REFRESH; IDLE -> REFRESH. Entering REFRESH clears counter and pending. REFRESH lasts T_REF cycles, then IDLE. Contents retained.
- Reset: asynchronous to IDLE; latched request dropped; all array words, rdata, counter cleared to 0.

## Timing
- Reset values: req_ready 0 (1 in cycle after release), rdata 0, rdata_valid 0, row_open 0, refreshing 0.
- Read latency (accept edge to rdata_valid high): hit 1; from IDLE T_ACT+1; miss from OPEN T_PRE+T_ACT+1.
- Throughput: back-to-back hits one per cycle; req_ready low for the whole PRECHARGE/ACTIVATE/REFRESH sequence, high again in the cycle rdata_valid rises.
- Read following a write to the same address in the next cycle returns the written data.
- Refresh becoming pending at the same edge as an accept: request is accepted and completes first.
- rst asserted mid-sequence: outputs reach reset values immediately, no late rdata_valid after release.

## Test plan
- Reset, write 0xDEADBEEF to addr 0x03 (byte_en 0xF) from IDLE -> req_ready low 2 cycles, row_open=1; read 0x03 -> rdata 0xDEADBEEF, latency 1.
- Write 0x11223344 to 0x05 with byte_en 0x5 over prior 0xAABBCCDD -> read returns 0xAA22CC44.
- Open row 0 (addr 0x02), read addr 0x12 (row 1) -> rdata_valid exactly 5 cycles after accept, row_open stays 1, req_ready low 4 cycles.
- Hold req_valid with hit reads for 70 cycles -> refreshing high 4 cycles after a 2-cycle precharge near cycle 63, row_open 0, subsequent read pays T_ACT+1 and data intact.
- Accept miss, drop rst at ACTIVATE cycle 1 -> all outputs 0 asynchronously, no rdata_valid after release, read of any addr returns 0.
- Back-to-back hit write 0x5 then read 0x5 on consecutive edges -> read returns new data, one request per cycle.
